block_collision_scanner: RTL and testbench
==========================================

// Module: block_collision_scanner
// PURPOSE
//  Reads the platform grid held by the block manager and finds the first
//  active block the doodle lands on. The scan runs once per start request.
//  It walks every grid slot, one read per cycle.
//  Outputs drive the block manager's collisionX / collisionY / hasCollide
//  inputs and the physics unit's bounce logic.
// PARAMETERS
//  SCREEN_WIDTH   640  screen width in pixels
//  SCREEN_HEIGHT  480  screen height in pixels
//  BLOCK_WIDTH    64   block width in pixels; grid columns W = SCREEN_WIDTH/BLOCK_WIDTH
//  BLOCK_HEIGHT   16   block height in pixels; grid rows H = SCREEN_HEIGHT/BLOCK_HEIGHT
//  DOODLE_WIDTH   32   doodle sprite width in pixels
// PORTS
//  clk          in   1   single clock; all logic on rising edge
//  reset        in   1   synchronous, active-high
//  start        in   1   1-cycle request; doodleX/doodleY/isFalling sampled with it
//  doodleX      in   32  left pixel of doodle (unsigned)
//  doodleY      in   32  feet pixel of doodle; Y grows upward (unsigned)
//  isFalling    in   1   doodle vertical velocity <= 0
//  rdCol        out  32  column index i of block being read
//  rdRow        out  32  row index j of block being read
//  blockX       in   32  blocksX[i][j], valid 1 cycle after rdCol/rdRow
//  blockY       in   32  blocksY[i][j], valid 1 cycle after rdCol/rdRow
//  blockActive  in   1   isBlockActive[i][j], same 1-cycle latency
//  busy         out  1   scan in progress
//  done         out  1   1-cycle pulse: result valid
//  hasCollide   out  1   1-cycle pulse, only together with done: hit found
//  collisionX   out  32  column index of hit; held until the next start
//  collisionY   out  32  row index of hit; held until the next start
// BEHAVIOUR
//  Reset values: all outputs are 0, and the FSM is in IDLE.
//  The doodle snapshot is latched on start; it does not change during a scan.
//  FSM states: IDLE -> SCAN -> WAIT -> IDLE.
//   IDLE:
//    - start=1 and isFalling=1: rdCol=0 and rdRow=0 are set, busy=1, go to SCAN.
//    - start=1 and isFalling=0: the scan is skipped. done=1 and hasCollide=0
//      on the next cycle. collisionX/Y are cleared to 0.
//    - start=0: stay in IDLE.
//   SCAN:
//    - The address advances every cycle, row-major: i=0..W-1 is the inner
//      loop, j=0..H-1 is the outer loop.
//    - Each cycle, the data returned for the previous address is compared.
//   WAIT:
//    - One cycle after the last address, to compare the final read.
//    - The FSM enters WAIT only if no hit was found yet.
//  Hit test (all arithmetic is 33-bit unsigned; no wrap):
//    blockActive
//    && doodleX + DOODLE_WIDTH > blockX
//    && doodleX < blockX + BLOCK_WIDTH
//    && blockY <= doodleY
//    && doodleY < blockY + BLOCK_HEIGHT
//  First hit wins. On a hit, the scan stops at once:
//   - The reads already in flight are discarded.
//   - collisionX/Y get the index of the hit.
//   - done=1 and hasCollide=1 on the next cycle.
//   - busy falls in that same cycle.
//  Latency: start at cycle t; address k (k = j*W + i) is presented in cycle t+1+k.
//   - Hit at k: done is high in cycle t+3+k.
//   - No hit: done is high in cycle t+2+W*H, with hasCollide=0 and collisionX/Y=0.
//  start while busy=1 is ignored; no queueing.
//  start in the same cycle as done is accepted; that cycle counts as IDLE.
//  reset mid-scan: the next cycle is IDLE with all outputs 0; no done pulse.
//  rdCol/rdRow hold their last value while IDLE.
// TESTING
//  1. Bench setup:
//     - The bench memory model has 1-cycle latency.
//     - All blocks are active, with blockX = i*64 and blockY = j*16.
//  2. Doodle (100, 5), falling, start at t.
//     -> hit at col 1, row 0: collisionX=1, collisionY=0, hasCollide=1, done at t+4.
//  3. Same snapshot, but only block (2,0) is active.
//     -> collisionX=2, collisionY=0, done at t+5. Confirms the overlap edge at x=128.
//  4. Doodle (100, 5) with isFalling=0.
//     -> done at t+1, hasCollide=0, busy never asserts.
//  5. All blocks inactive, falling.
//     -> done at t+302 (W*H = 300), hasCollide=0. A second start during busy is ignored.
//  6. reset asserted 10 cycles into a scan.
//     -> IDLE and all outputs 0 on the next cycle; no done.
//     -> A new start then gives a correct result.
//  7. Doodle (0xFFFFFFF0, 5) with a block at X = 0xFFFFFFC0.
//     -> the hit is detected; 33-bit compare, no overflow false-miss.

Source files
------------

// File: rtl/block_collision_scanner_if.sv
// block_collision_scanner_if: scan request, block-manager read port and collision result bundle
interface block_collision_scanner_if;
  logic        start;
  logic [31:0] doodleX;
  logic [31:0] doodleY;
  logic        isFalling;
  logic [31:0] rdCol;
  logic [31:0] rdRow;
  logic [31:0] blockX;
  logic [31:0] blockY;
  logic        blockActive;
  logic        busy;
  logic        done;
  logic        hasCollide;
  logic [31:0] collisionX;
  logic [31:0] collisionY;
  modport master (
    output start, doodleX, doodleY, isFalling, blockX, blockY, blockActive,
    input  rdCol, rdRow, busy, done, hasCollide, collisionX, collisionY
  );
  modport slave (
    input  start, doodleX, doodleY, isFalling, blockX, blockY, blockActive,
    output rdCol, rdRow, busy, done, hasCollide, collisionX, collisionY
  );
endinterface

// File: rtl/block_collision_scanner.sv
// block_collision_scanner: walks the block grid one read per cycle and reports the first block the falling doodle lands on
module block_collision_scanner #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int BLOCK_WIDTH   = 64,
  parameter int BLOCK_HEIGHT  = 16,
  parameter int DOODLE_WIDTH  = 32
) (
  input logic clk,
  input logic reset,
  block_collision_scanner_if.slave bus
);
  localparam int W = SCREEN_WIDTH / BLOCK_WIDTH;
  localparam int H = SCREEN_HEIGHT / BLOCK_HEIGHT;
  typedef enum logic [1:0] {IDLE, SCAN, WAIT} state_t;
  state_t      state;
  logic [31:0] dx, dy, pcol, prow;
  logic        vld, hit, last, col_end;
  // 33-bit compares so a doodle or block near 2^32 cannot wrap into a false miss
  always_comb begin
    hit = vld && bus.blockActive
      && ({1'b0, dx} + 33'(DOODLE_WIDTH) > {1'b0, bus.blockX})
      && ({1'b0, dx} < {1'b0, bus.blockX} + 33'(BLOCK_WIDTH))
      && (bus.blockY <= dy)
      && ({1'b0, dy} < {1'b0, bus.blockY} + 33'(BLOCK_HEIGHT));
    col_end = bus.rdCol == 32'(W - 1);
    last = col_end && bus.rdRow == 32'(H - 1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      dx             <= '0;
      dy             <= '0;
      pcol           <= '0;
      prow           <= '0;
      vld            <= 1'b0;
      bus.rdCol      <= '0;
      bus.rdRow      <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.hasCollide <= 1'b0;
      bus.collisionX <= '0;
      bus.collisionY <= '0;
    end else begin
      bus.done       <= 1'b0;
      bus.hasCollide <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          bus.collisionX <= '0;
          bus.collisionY <= '0;
          if (bus.isFalling) begin
            dx        <= bus.doodleX;
            dy        <= bus.doodleY;
            bus.rdCol <= '0;
            bus.rdRow <= '0;
            bus.busy  <= 1'b1;
            vld       <= 1'b0;
            state     <= SCAN;
          end else begin
            bus.done <= 1'b1;
          end
        end
        SCAN: if (hit) begin
          bus.collisionX <= pcol;
          bus.collisionY <= prow;
          bus.done       <= 1'b1;
          bus.hasCollide <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end else begin
          pcol  <= bus.rdCol;
          prow  <= bus.rdRow;
          vld   <= 1'b1;
          state <= last ? WAIT : SCAN;
          if (!last) begin
            bus.rdCol <= col_end ? '0 : bus.rdCol + 32'd1;
            bus.rdRow <= col_end ? bus.rdRow + 32'd1 : bus.rdRow;
          end
        end
        WAIT: begin
          bus.collisionX <= hit ? pcol : '0;
          bus.collisionY <= hit ? prow : '0;
          bus.hasCollide <= hit;
          bus.done       <= 1'b1;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_block_collision_scanner.sv
// tb_block_collision_scanner: directed scans against a 1-cycle-latency grid memory with hand-computed results
module tb_block_collision_scanner;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  block_collision_scanner_if bus();
  block_collision_scanner dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] bx [16][32];
  logic [31:0] by [16][32];
  logic        ba [16][32];
  always @(posedge clk) begin
    bus.blockX      <= bx[bus.rdCol[3:0]][bus.rdRow[4:0]];
    bus.blockY      <= by[bus.rdCol[3:0]][bus.rdRow[4:0]];
    bus.blockActive <= ba[bus.rdCol[3:0]][bus.rdRow[4:0]];
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int   done_cnt = 0;
  logic busy_seen = 1'b0;
  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.busy) busy_seen = 1'b1;
  end
  int chk_cnt = 0;
  int pass_cnt = 0;
  int ts, dc;
  task automatic fill(input logic act);
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 32; j++) begin
        bx[i][j] = 32'(i * 64);
        by[i][j] = 32'(j * 16);
        ba[i][j] = act;
      end
  endtask
  task automatic start_scan(input logic [31:0] x, input logic [31:0] y, input logic f);
    @(negedge clk);
    bus.start = 1'b1;
    bus.doodleX = x;
    bus.doodleY = y;
    bus.isFalling = f;
    ts = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    bus.doodleX = 32'hDEAD_BEEF;
    bus.doodleY = 32'h0;
    bus.isFalling = 1'b0;
  endtask
  task automatic wait_done();
    for (int n = 0; n < 400 && !bus.done; n++) @(negedge clk);
    dc = bus.done ? cyc - ts : -1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if ({bus.busy, bus.done, bus.hasCollide} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.hasCollide});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.collisionX, bus.collisionY, bus.rdCol, bus.rdRow} !== 128'h0) $display("FAIL reset_values got cx=%0d cy=%0d col=%0d row=%0d want all 0", bus.collisionX, bus.collisionY, bus.rdCol, bus.rdRow);
    else pass_cnt++;
    reset = 1'b0;
  endtask
  task automatic test_hit();
    fill(1'b1);
    start_scan(32'd100, 32'd5, 1'b1);
    chk_cnt++;
    if ({bus.rdCol, bus.rdRow, bus.busy} !== {32'd0, 32'd0, 1'b1}) $display("FAIL hit_first_addr got col=%0d row=%0d busy=%b want 0 0 1", bus.rdCol, bus.rdRow, bus.busy);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (bus.rdCol !== 32'd1) $display("FAIL hit_second_addr got=%0d want=1", bus.rdCol);
    else pass_cnt++;
    wait_done();
    chk_cnt++;
    if (dc !== 4) $display("FAIL hit_latency got=%0d want=4", dc);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.hasCollide, bus.busy, bus.collisionX, bus.collisionY} !== {1'b1, 1'b0, 32'd1, 32'd0}) $display("FAIL hit_result got hc=%b busy=%b cx=%0d cy=%0d want 1 0 1 0", bus.hasCollide, bus.busy, bus.collisionX, bus.collisionY);
    else pass_cnt++;
    chk_cnt++;
    if ({bus.rdCol, bus.rdRow} !== {32'd2, 32'd0}) $display("FAIL hit_addr_stop got col=%0d row=%0d want 2 0", bus.rdCol, bus.rdRow);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if ({bus.done, bus.hasCollide, bus.collisionX} !== {1'b0, 1'b0, 32'd1}) $display("FAIL hit_pulse_hold got done=%b hc=%b cx=%0d want 0 0 1", bus.done, bus.hasCollide, bus.collisionX);
    else pass_cnt++;
  endtask
  task automatic test_edge();
    fill(1'b0);
    ba[2][0] = 1'b1;
    start_scan(32'd100, 32'd5, 1'b1);
    wait_done();
    chk_cnt++;
    if ({dc, bus.hasCollide, bus.collisionX, bus.collisionY} !== {32'd5, 1'b1, 32'd2, 32'd0}) $display("FAIL edge_x128 got lat=%0d hc=%b cx=%0d cy=%0d want 5 1 2 0", dc, bus.hasCollide, bus.collisionX, bus.collisionY);
    else pass_cnt++;
  endtask
  task automatic test_not_falling();
    fill(1'b1);
    @(negedge clk);
    busy_seen = 1'b0;
    start_scan(32'd100, 32'd5, 1'b0);
    wait_done();
    chk_cnt++;
    if ({dc, bus.hasCollide, bus.collisionX, bus.collisionY} !== {32'd1, 1'b0, 32'd0, 32'd0}) $display("FAIL skip_result got lat=%0d hc=%b cx=%0d cy=%0d want 1 0 0 0", dc, bus.hasCollide, bus.collisionX, bus.collisionY);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (busy_seen !== 1'b0) $display("FAIL skip_busy got=%b want=0", busy_seen);
    else pass_cnt++;
  endtask
  task automatic test_no_hit();
    int d0;
    fill(1'b0);
    d0 = done_cnt;
    start_scan(32'd100, 32'd5, 1'b1);
    repeat (10) @(negedge clk);
    chk_cnt++;
    if ({bus.rdCol, bus.rdRow} !== {32'd0, 32'd1}) $display("FAIL row_wrap got col=%0d row=%0d want 0 1", bus.rdCol, bus.rdRow);
    else pass_cnt++;
    bus.start = 1'b1;
    bus.isFalling = 1'b1;
    bus.doodleX = 32'd100;
    bus.doodleY = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    bus.isFalling = 1'b0;
    wait_done();
    chk_cnt++;
    if ({dc, bus.hasCollide, bus.collisionX, bus.collisionY} !== {32'd302, 1'b0, 32'd0, 32'd0}) $display("FAIL nohit_result got lat=%0d hc=%b cx=%0d cy=%0d want 302 0 0 0", dc, bus.hasCollide, bus.collisionX, bus.collisionY);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    chk_cnt++;
    if (done_cnt - d0 !== 1) $display("FAIL nohit_single_done got=%0d want=1", done_cnt - d0);
    else pass_cnt++;
  endtask
  task automatic test_reset_mid();
    int d0;
    fill(1'b0);
    start_scan(32'd100, 32'd5, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    d0 = done_cnt;
    chk_cnt++;
    if ({bus.busy, bus.done, bus.hasCollide, bus.rdCol, bus.rdRow} !== 67'h0) $display("FAIL midreset_outputs got busy=%b done=%b hc=%b col=%0d row=%0d want all 0", bus.busy, bus.done, bus.hasCollide, bus.rdCol, bus.rdRow);
    else pass_cnt++;
    repeat (320) @(negedge clk);
    chk_cnt++;
    if (done_cnt !== d0) $display("FAIL midreset_no_done got=%0d want=%0d", done_cnt, d0);
    else pass_cnt++;
    fill(1'b1);
    start_scan(32'd100, 32'd5, 1'b1);
    wait_done();
    chk_cnt++;
    if ({dc, bus.hasCollide, bus.collisionX, bus.collisionY} !== {32'd4, 1'b1, 32'd1, 32'd0}) $display("FAIL midreset_rescan got lat=%0d hc=%b cx=%0d cy=%0d want 4 1 1 0", dc, bus.hasCollide, bus.collisionX, bus.collisionY);
    else pass_cnt++;
  endtask
  task automatic test_overflow();
    fill(1'b0);
    bx[3][0] = 32'hFFFF_FFC0;
    ba[3][0] = 1'b1;
    start_scan(32'hFFFF_FFF0, 32'd5, 1'b1);
    wait_done();
    chk_cnt++;
    if ({dc, bus.hasCollide, bus.collisionX, bus.collisionY} !== {32'd6, 1'b1, 32'd3, 32'd0}) $display("FAIL overflow_hit got lat=%0d hc=%b cx=%0d cy=%0d want 6 1 3 0", dc, bus.hasCollide, bus.collisionX, bus.collisionY);
    else pass_cnt++;
  endtask
  task automatic test_back_to_back();
    fill(1'b1);
    start_scan(32'd100, 32'd5, 1'b1);
    wait_done();
    bus.start = 1'b1;
    bus.isFalling = 1'b0;
    ts = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    chk_cnt++;
    if ({bus.done, bus.hasCollide, bus.collisionX, 32'(cyc - ts)} !== {1'b1, 1'b0, 32'd0, 32'd1}) $display("FAIL b2b_start got done=%b hc=%b cx=%0d lat=%0d want 1 0 0 1", bus.done, bus.hasCollide, bus.collisionX, cyc - ts);
    else pass_cnt++;
  endtask
  initial begin
    bus.start = 1'b0;
    bus.doodleX = '0;
    bus.doodleY = '0;
    bus.isFalling = 1'b0;
    fill(1'b1);
    test_reset();
    test_hit();
    test_edge();
    test_not_falling();
    test_no_hit();
    test_reset_mid();
    test_overflow();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
